prog_ram: RTL and testbench

Parametrised, manually programmable main memory for the 8-bit computer, replacing the fixed 16×8 RAM. It serves the CPU bus in run mode and the switch-panel loader in program mode. Memory is cleared by a one-word-per-cycle sweep after reset or on request, not by a flop-array reset. The load button is synchronised and edge-detected, so one press writes exactly one word.

---
 rtl/prog_ram_pkg.sv | 15 +
 rtl/btn_sync_edge.sv | 36 +++
 rtl/prog_ram.sv | 138 +++++++++++++
 tb/tb_prog_ram.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_ram_pkg.sv
// Shared types and default geometry for the programmable main memory.
// Consumers: prog_ram and the CPU top (width/depth defaults).
package prog_ram_pkg;

  localparam int RAM_DATA_W = 8;
  localparam int RAM_ADDR_W = 4;
  localparam int RAM_DEPTH  = 2**RAM_ADDR_W;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    PROG  = 2'd2
  } ram_state_t;

endpackage

// File: rtl/btn_sync_edge.sv
// Push-button synchroniser plus rising-edge detector; pulse is one cycle, SYNC_STAGES edges after sampling.
// A press held across reset is masked until the button has been seen released.
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   prev_q;
  logic                   armed_q;

  // fill_q marks when the synchroniser holds only post-reset samples; a low level seen then arms the detector
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      fill_q  <= '0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev_q <= sync_q[SYNC_STAGES-1];
      if (fill_q[SYNC_STAGES-1] && !sync_q[SYNC_STAGES-1]) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q & armed_q;

endmodule

// File: rtl/prog_ram.sv
// Switch-programmable main memory: CPU bus in RUN, panel loader in PROG, DEPTH-cycle zero sweep in CLEAR.
// Combinational read; writes commit on the edge. Optional RAM_AUTOINC_EN gives an auto-incrementing load pointer.
module prog_ram
  import prog_ram_pkg::*;
#(
  parameter int DATA_W      = RAM_DATA_W,
  parameter int ADDR_W      = RAM_ADDR_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ram_in_en,
  input  logic [ADDR_W-1:0] ram_in_addr,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  input  logic [ADDR_W-1:0] sw_addr,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              load_btn,
  input  logic              clear_req,
  output logic              busy,
  output logic [ADDR_W-1:0] prog_addr
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  ram_state_t        state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              btn_pulse;
  logic              prog_wr;
  logic [ADDR_W-1:0] man_addr;

  btn_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_btn (
    .clk  (clk),
    .reset(reset),
    .btn  (load_btn),
    .pulse(btn_pulse)
  );

  // Registered state decides, so a pulse coinciding with PROG->RUN still lands
  assign prog_wr = (state_q == PROG) && !clear_req && btn_pulse;

`ifdef RAM_AUTOINC_EN
  logic [ADDR_W-1:0] prog_ptr_q;
  logic              prog_enter;

  assign prog_enter = (state_d == PROG) && (state_q != PROG);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prog_ptr_q <= '0;
    end else if (prog_enter) begin
      prog_ptr_q <= sw_addr;
    end else if (prog_wr) begin
      prog_ptr_q <= prog_ptr_q + 1'b1;
    end
  end

  assign man_addr = prog_ptr_q;
`else
  assign man_addr = sw_addr;
`endif

  assign prog_addr = man_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    wr_en     = 1'b0;
    wr_addr   = ram_in_addr;
    wr_data   = bus_in;
    case (state_q)
      CLEAR: begin
        wr_en     = 1'b1;
        wr_addr   = clr_ptr_q;
        wr_data   = '0;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LAST_ADDR) begin
          state_d   = start ? RUN : PROG;
          clr_ptr_d = '0;
        end
      end
      RUN: begin
        if (clear_req) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end else begin
          wr_en = ram_in_en;
          if (!start) state_d = PROG;
        end
      end
      PROG: begin
        if (clear_req) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end else begin
          wr_en   = prog_wr;
          wr_addr = man_addr;
          wr_data = sw_data;
          if (start) state_d = RUN;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_ptr_d = '0;
      end
    endcase
  end

  // Array has no reset; contents are defined by the CLEAR sweep
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign busy    = (state_q == CLEAR);
  assign bus_out = busy ? '0 : mem[ram_in_addr];

endmodule

// File: tb/tb_prog_ram.sv
// Directed self-checking bench for prog_ram (default geometry 16x8, two-stage synchroniser).
module tb_prog_ram;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       ram_in_en;
  logic [3:0] ram_in_addr;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic [3:0] sw_addr;
  logic [7:0] sw_data;
  logic       load_btn;
  logic       clear_req;
  logic       busy;
  logic [3:0] prog_addr;

  int pass_cnt  = 0;
  int total_cnt = 0;

  prog_ram #(
    .DATA_W(8),
    .ADDR_W(4),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ram_in_en  (ram_in_en),
    .ram_in_addr(ram_in_addr),
    .bus_in     (bus_in),
    .bus_out    (bus_out),
    .sw_addr    (sw_addr),
    .sw_data    (sw_data),
    .load_btn   (load_btn),
    .clear_req  (clear_req),
    .busy       (busy),
    .prog_addr  (prog_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  // Counts negedge samples with busy high, bounded to 100 cycles
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 100 && busy === 1'b1; i++) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    int n;
    reset = 1'b1; start = 1'b1; ram_in_en = 1'b0; ram_in_addr = '0; bus_in = '0;
    sw_addr = '0; sw_data = '0; load_btn = 1'b0; clear_req = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++; if (busy !== 1'b1) $display("FAIL reset_busy: got %b expected 1", busy); else pass_cnt++;
    total_cnt++; if (bus_out !== 8'h00) $display("FAIL reset_bus_out: got %h expected 00", bus_out); else pass_cnt++;
    total_cnt++; if (prog_addr !== 4'h0) $display("FAIL reset_prog_addr: got %h expected 0", prog_addr); else pass_cnt++;
    reset = 1'b0;
    count_busy(n);
    total_cnt++; if (n != 16) $display("FAIL reset_sweep_len: got %0d expected 16", n); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy_after: got %b expected 0", busy); else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      ram_in_addr = 4'(i);
      #1;
      total_cnt++; if (bus_out !== 8'h00) $display("FAIL reset_zero[%0d]: got %h expected 00", i, bus_out); else pass_cnt++;
    end
    sw_addr = 4'hB;
    #1;
`ifdef RAM_AUTOINC_EN
    total_cnt++; if (prog_addr !== 4'h0) $display("FAIL prog_addr_ptr: got %h expected 0", prog_addr); else pass_cnt++;
`else
    total_cnt++; if (prog_addr !== 4'hB) $display("FAIL prog_addr_follow: got %h expected b", prog_addr); else pass_cnt++;
`endif
  endtask

  task automatic test_run_write;
    @(negedge clk);
    ram_in_en = 1'b1; ram_in_addr = 4'h5; bus_in = 8'hA7;
    sw_addr = 4'h5; sw_data = 8'h33; load_btn = 1'b1;
    @(negedge clk);
    ram_in_en = 1'b0;
    #1;
    total_cnt++; if (bus_out !== 8'hA7) $display("FAIL run_write: got %h expected a7", bus_out); else pass_cnt++;
    repeat (5) @(negedge clk);
    total_cnt++; if (bus_out !== 8'hA7) $display("FAIL run_btn_ignored: got %h expected a7", bus_out); else pass_cnt++;
    load_btn = 1'b0;
    ram_in_en = 1'b1; ram_in_addr = 4'hA; bus_in = 8'h3C;
    @(negedge clk);
    ram_in_en = 1'b0;
    #1;
    total_cnt++; if (bus_out !== 8'h3C) $display("FAIL run_write_a: got %h expected 3c", bus_out); else pass_cnt++;
    ram_in_addr = 4'h5;
    #1;
    total_cnt++; if (bus_out !== 8'hA7) $display("FAIL run_keep_5: got %h expected a7", bus_out); else pass_cnt++;
    repeat (4) @(negedge clk);
  endtask

`ifndef RAM_AUTOINC_EN
  task automatic test_prog_write;
    start = 1'b0;
    @(negedge clk);
    ram_in_en = 1'b1; ram_in_addr = 4'h6; bus_in = 8'h99;
    @(negedge clk);
    ram_in_en = 1'b0;
    #1;
    total_cnt++; if (bus_out !== 8'h00) $display("FAIL prog_bus_ignored: got %h expected 00", bus_out); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL prog_busy: got %b expected 0", busy); else pass_cnt++;
    sw_addr = 4'h3; sw_data = 8'h5C; ram_in_addr = 4'h3;
    #1;
    total_cnt++; if (prog_addr !== 4'h3) $display("FAIL prog_addr_sw: got %h expected 3", prog_addr); else pass_cnt++;
    load_btn = 1'b1;
    @(negedge clk);
    total_cnt++; if (bus_out !== 8'h00) $display("FAIL btn_early1: got %h expected 00", bus_out); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (bus_out !== 8'h00) $display("FAIL btn_early2: got %h expected 00", bus_out); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (bus_out !== 8'h5C) $display("FAIL btn_write: got %h expected 5c", bus_out); else pass_cnt++;
    sw_data = 8'h77;
    repeat (7) @(negedge clk);
    total_cnt++; if (bus_out !== 8'h5C) $display("FAIL btn_hold_once: got %h expected 5c", bus_out); else pass_cnt++;
    load_btn = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_prog_to_run_same_cycle;
    sw_addr = 4'h7; sw_data = 8'h4D; ram_in_addr = 4'h7; load_btn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    total_cnt++; if (bus_out !== 8'h4D) $display("FAIL switch_write: got %h expected 4d", bus_out); else pass_cnt++;
    load_btn = 1'b0;
    ram_in_en = 1'b1; bus_in = 8'hE4;
    @(negedge clk);
    ram_in_en = 1'b0;
    #1;
    total_cnt++; if (bus_out !== 8'hE4) $display("FAIL switch_run_mode: got %h expected e4", bus_out); else pass_cnt++;
    repeat (4) @(negedge clk);
  endtask
`else
  task automatic press(input logic [7:0] d);
    sw_data = d; load_btn = 1'b1;
    repeat (3) @(negedge clk);
    load_btn = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_autoinc;
    sw_addr = 4'hE; start = 1'b0;
    @(negedge clk);
    sw_addr = 4'h2;
    press(8'h11);
    press(8'h22);
    press(8'h33);
    total_cnt++; if (prog_addr !== 4'h1) $display("FAIL autoinc_ptr: got %h expected 1", prog_addr); else pass_cnt++;
    ram_in_addr = 4'hE; #1;
    total_cnt++; if (bus_out !== 8'h11) $display("FAIL autoinc_e: got %h expected 11", bus_out); else pass_cnt++;
    ram_in_addr = 4'hF; #1;
    total_cnt++; if (bus_out !== 8'h22) $display("FAIL autoinc_f: got %h expected 22", bus_out); else pass_cnt++;
    ram_in_addr = 4'h0; #1;
    total_cnt++; if (bus_out !== 8'h33) $display("FAIL autoinc_0: got %h expected 33", bus_out); else pass_cnt++;
    ram_in_addr = 4'h2; #1;
    total_cnt++; if (bus_out !== 8'h00) $display("FAIL autoinc_sw_unused: got %h expected 00", bus_out); else pass_cnt++;
    start = 1'b1;
    @(negedge clk);
  endtask
`endif

  task automatic test_clear_req;
    int n;
    @(negedge clk);
    ram_in_en = 1'b1; ram_in_addr = 4'h2; bus_in = 8'hFF; clear_req = 1'b1;
    @(negedge clk);
    ram_in_en = 1'b0; clear_req = 1'b0; ram_in_addr = 4'h5;
    #1;
    total_cnt++; if (busy !== 1'b1) $display("FAIL clear_busy: got %b expected 1", busy); else pass_cnt++;
    total_cnt++; if (bus_out !== 8'h00) $display("FAIL clear_bus_out: got %h expected 00", bus_out); else pass_cnt++;
    count_busy(n);
    total_cnt++; if (n != 16) $display("FAIL clear_sweep_len: got %0d expected 16", n); else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      ram_in_addr = 4'(i);
      #1;
      total_cnt++; if (bus_out !== 8'h00) $display("FAIL clear_zero[%0d]: got %h expected 00", i, bus_out); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_sweep;
    int n;
    @(negedge clk);
    ram_in_en = 1'b1; ram_in_addr = 4'h4; bus_in = 8'h5A;
    @(negedge clk);
    ram_in_en = 1'b0;
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1; load_btn = 1'b1; start = 1'b0; sw_addr = 4'h9; sw_data = 8'h66;
    @(negedge clk);
    total_cnt++; if (busy !== 1'b1) $display("FAIL midreset_busy: got %b expected 1", busy); else pass_cnt++;
    reset = 1'b0;
    count_busy(n);
    total_cnt++; if (n != 16) $display("FAIL midreset_sweep_len: got %0d expected 16", n); else pass_cnt++;
    ram_in_addr = 4'h4; #1;
    total_cnt++; if (bus_out !== 8'h00) $display("FAIL midreset_cleared: got %h expected 00", bus_out); else pass_cnt++;
    ram_in_addr = 4'h9;
    repeat (5) @(negedge clk);
    total_cnt++; if (bus_out !== 8'h00) $display("FAIL held_press_masked: got %h expected 00", bus_out); else pass_cnt++;
    load_btn = 1'b0;
    repeat (4) @(negedge clk);
    load_btn = 1'b1;
    repeat (4) @(negedge clk);
    total_cnt++; if (bus_out !== 8'h66) $display("FAIL repress_write: got %h expected 66", bus_out); else pass_cnt++;
    load_btn = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_run_write();
`ifndef RAM_AUTOINC_EN
    test_prog_write();
    test_prog_to_run_same_cycle();
`else
    test_autoinc();
`endif
    test_clear_req();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
